// File: rtl/jk_pkg.sv
// Shared definitions for the JK register array: mode encoding.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_MODE_JK   = 2'd0,
        JK_MODE_UP   = 2'd1,
        JK_MODE_DOWN = 2'd2,
        JK_MODE_LOAD = 2'd3
    } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous reset and clock enable.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);

    // JK state update: hold / clear / set / toggle; reset wins over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= rst_val;
        end else if (en) begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_reg_array.sv
// Bank of JK cells reused as a JK register, up/down counter or loadable register.
module jk_reg_array
    import jk_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             changed
);

    jk_mode_t         w_mode;
    logic [WIDTH-1:0] w_up_carry;
    logic [WIDTH-1:0] w_dn_carry;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_will_change;
    logic             r_changed;

    assign w_mode = jk_mode_t'(mode);

    // Prefix-AND carry chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        w_up_carry    = '0;
        w_dn_carry    = '0;
        w_up_carry[0] = 1'b1;
        w_dn_carry[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            w_up_carry[i] = w_up_carry[i-1] & Q[i-1];
            w_dn_carry[i] = w_dn_carry[i-1] & ~Q[i-1];
        end
    end

    // Per-mode steering of the effective J/K inputs of every cell.
    always_comb begin
        w_j = '0;
        w_k = '0;
        case (w_mode)
            JK_MODE_JK: begin
                w_j = J;
                w_k = K;
            end
            JK_MODE_UP: begin
                w_j = w_up_carry;
                w_k = w_up_carry;
            end
            JK_MODE_DOWN: begin
                w_j = w_dn_carry;
                w_k = w_dn_carry;
            end
            default: begin
                w_j = D;
                w_k = ~D;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk     (clk),
                .reset   (reset),
                .en      (en),
                .j       (w_j[gi]),
                .k       (w_k[gi]),
                .rst_val (RESET_VAL[gi]),
                .q       (Q[gi])
            );
        end
    endgenerate

    // A bit flips exactly when (j & ~q) or (k & q); so the word changes iff any bit does.
    assign w_will_change = en & (|((w_j & ~Q) | (w_k & Q)));

    // changed flags the edge at which Q moved; reset always clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_will_change;
        end
    end

    assign changed = r_changed;
    assign Qn      = ~Q;
    assign tc      = en & (((w_mode == JK_MODE_UP)   & (&Q)) |
                           ((w_mode == JK_MODE_DOWN) & ~(|Q)));

endmodule

// File: tb/tb_jk_reg_array.sv
// Scoreboard bench for jk_reg_array (WIDTH=4, RESET_VAL=0101).
module tb_jk_reg_array;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] J;
    logic [3:0] K;
    logic [3:0] D;
    logic [3:0] Q;
    logic [3:0] Qn;
    logic       tc;
    logic       changed;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       tc;
        logic       chg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 1'b0;

    jk_reg_array #(
        .WIDTH     (4),
        .RESET_VAL (4'b0101)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .J       (J),
        .K       (K),
        .D       (D),
        .Q       (Q),
        .Qn      (Qn),
        .tc      (tc),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field,
                       input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %b expected %b", nm, field, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then queue the state expected after the edge.
    task automatic step(input string nm, input logic r, input logic e,
                        input logic [1:0] m, input logic [3:0] jv,
                        input logic [3:0] kv, input logic [3:0] dv,
                        input logic [3:0] eq, input logic etc, input logic echg);
        exp_t x;
        reset = r;
        en    = e;
        mode  = m;
        J     = jv;
        K     = kv;
        D     = dv;
        @(posedge clk);
        x.name = nm;
        x.q    = eq;
        x.tc   = etc;
        x.chg  = echg;
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    // Monitor: each falling edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk(x.name, "Q",       Q,               x.q);
                chk(x.name, "Qn",      Qn,              ~x.q);
                chk(x.name, "tc",      {3'b000, tc},      {3'b000, x.tc});
                chk(x.name, "changed", {3'b000, changed}, {3'b000, x.chg});
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b1; mode = 2'd1; J = '0; K = '0; D = '0;
        @(negedge clk);
        #1;
        //    name          rst en  mode  J        K        D        Q        tc chg
        step("reset0",      1, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 0, 0);
        step("reset1",      1, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 0, 0);
        step("jk_setclr",   0, 1, 2'd0, 4'b1100, 4'b0011, 4'b0000, 4'b1100, 0, 1);
        step("jk_toggle",   0, 1, 2'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0011, 0, 1);
        step("jk_hold",     0, 1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 0, 0);
        step("ld_1110",     0, 1, 2'd3, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 0, 1);
        step("up_1111",     0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 1);
        step("up_wrap",     0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        step("up_0001",     0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 1);
        step("dn_0000",     0, 1, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1);
        step("dn_wrap",     0, 1, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1);
        step("dn_1110",     0, 1, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 0, 1);
        step("frz0",        0, 0, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 0, 0);
        step("frz1",        0, 0, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 0, 0);
        step("frz2",        0, 0, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 0, 0);
        step("ld_1001",     0, 1, 2'd3, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 0, 1);
        step("ld_disabled", 0, 0, 2'd3, 4'b0000, 4'b0000, 4'b0110, 4'b1001, 0, 0);
        step("up_1010",     0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 0, 1);
        step("rst_mid_up",  1, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 0, 0);
        step("jk_set_all",  0, 1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 0, 1);
        step("up_en0_tc",   0, 0, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
        step("up_wrap2",    0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        step("ld_0000",     0, 1, 2'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step("dn_en0_tc",   0, 0, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        stim_done = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        if (!stim_done) begin
            $display("FAIL timeout: got stimulus incomplete expected complete");
            $display("%0d/%0d checks passed", n_pass, n_checks + 1);
            $fatal(1, "timeout");
        end
    end

endmodule
